// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } arb_state_e;

    localparam int unsigned REQ_CORE         = 0;
    localparam int unsigned REQ_DBG          = 1;
    localparam int unsigned DEFAULT_MAX_WAIT = 15;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone request wins; on a tie the one not served last wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] winner
);

    always_comb begin
        winner = req;
        if (&req) begin
            winner = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core controller and the debug/loader,
// with round-robin tie-breaking and a wait-cycle timeout abort.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          done_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                core_stall_o,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ready_i
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    arb_state_e          state_q, state_d;
    logic                owner_q, last_q, we_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [7:0]          wait_q;
    logic [1:0]          winner, owner_oh;
    logic                win_idx, timeout, busy;

    rr_arbiter_2 u_rr (
        .req    (req_i),
        .last   (last_q),
        .winner (winner)
    );

    assign win_idx  = (winner == 2'b10);
    assign timeout  = (wait_q == WAIT_LAST);
    assign busy     = (state_q == StBusy);
    assign owner_oh = (owner_q == 1'(REQ_CORE)) ? 2'b01 : 2'b10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req_i) state_d = StBusy;
            StBusy:  if (mem_ready_i || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            last_q  <= 1'(REQ_DBG);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_i) begin
                        owner_q <= win_idx;
                        we_q    <= we_i[win_idx];
                        addr_q  <= win_idx ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
                        wdata_q <= win_idx ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
                        wait_q  <= '0;
                    end
                end
                StBusy: begin
                    // A ready coinciding with timeout counts as success.
                    if (mem_ready_i) begin
                        rdata_q <= we_q ? '0 : mem_rdata_i;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDone: last_q <= owner_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt_o        = (busy && wait_q == 8'd0) ? owner_oh : 2'b00;
        done_o       = (state_q == StDone) ? owner_oh : 2'b00;
        err_o        = err_q;
        rdata_o      = rdata_q;
        core_stall_o = req_i[0] & ~done_o[0];
        mem_rd_o     = busy & ~we_q;
        mem_wr_o     = busy & we_q;
        mem_addr_o   = addr_q;
        mem_wdata_o  = wdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: read, round-robin, delayed write, timeout, reset abort.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req_i, we_i;
    logic [2*ADDR_W-1:0] addr_i;
    logic [2*DATA_W-1:0] wdata_i;
    logic [1:0]          gnt_o, done_o;
    logic                err_o, core_stall_o, mem_rd_o, mem_wr_o, mem_ready_i;
    logic [DATA_W-1:0]   rdata_o, mem_wdata_o, mem_rdata_i;
    logic [ADDR_W-1:0]   mem_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .core_stall_o (core_stall_o),
        .mem_rd_o     (mem_rd_o),
        .mem_wr_o     (mem_wr_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cnt;
        logic [1:0] exp_gnt;

        rst_n       = 1'b0;
        req_i       = 2'b00;
        we_i        = 2'b00;
        addr_i      = '0;
        wdata_i     = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;
        #1;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_done", done_o, 2'b00);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_strobes", {mem_rd_o, mem_wr_o}, 2'b00);
        chk("rst_addr", mem_addr_o, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Core read, memory ready on first busy cycle
        req_i  = 2'b01;
        addr_i = {32'h0, 32'h100};
        #1;
        chk("rd_stall_idle", core_stall_o, 1);
        tick();
        chk("rd_gnt", gnt_o, 2'b01);
        chk("rd_mem_rd", mem_rd_o, 1);
        chk("rd_mem_addr", mem_addr_o, 32'h100);
        chk("rd_done_early", done_o, 2'b00);
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        tick();
        chk("rd_done", done_o, 2'b01);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);
        chk("rd_err", err_o, 0);
        chk("rd_stall_done", core_stall_o, 0);
        chk("rd_strobe_off", mem_rd_o, 0);
        req_i       = 2'b00;
        mem_ready_i = 1'b0;
        tick();

        // Dual request after reset: strict alternation starting with core
        rst_n = 1'b0;
        #1;
        rst_n       = 1'b1;
        req_i       = 2'b11;
        mem_ready_i = 1'b1;
        exp_gnt     = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), gnt_o, exp_gnt);
            tick();
            chk($sformatf("rr_done%0d", i), done_o, exp_gnt);
            tick();
            exp_gnt = ~exp_gnt;
        end
        req_i       = 2'b00;
        mem_ready_i = 1'b0;
        tick();

        // Debug write with ready on the fifth busy cycle; inputs change mid-transaction
        req_i   = 2'b10;
        we_i    = 2'b10;
        addr_i  = {32'h40, 32'h300};
        wdata_i = {32'h1234, 32'h5555};
        tick();
        chk("wr_gnt", gnt_o, 2'b10);
        addr_i  = {32'hFFF, 32'h300};
        wdata_i = {32'h0, 32'h5555};
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("wr_strobe%0d", i), {mem_wr_o, mem_rd_o}, 2'b10);
            chk($sformatf("wr_addr%0d", i), mem_addr_o, 32'h40);
            chk($sformatf("wr_data%0d", i), mem_wdata_o, 32'h1234);
            if (i == 5) mem_ready_i = 1'b1;
            tick();
        end
        chk("wr_strobe_off", mem_wr_o, 0);
        chk("wr_done", done_o, 2'b10);
        chk("wr_err", err_o, 0);
        chk("wr_rdata", rdata_o, 0);
        req_i       = 2'b00;
        we_i        = 2'b00;
        mem_ready_i = 1'b0;
        tick();

        // Core read that never completes: timeout after 15 busy cycles
        req_i  = 2'b01;
        addr_i = {32'h0, 32'h200};
        tick();
        chk("to_gnt", gnt_o, 2'b01);
        chk("to_stall", core_stall_o, 1);
        busy_cnt = 0;
        while (mem_rd_o && busy_cnt < 40) begin
            busy_cnt++;
            tick();
        end
        chk("to_busy_cycles", busy_cnt, 15);
        chk("to_done", done_o, 2'b01);
        chk("to_err", err_o, 1);
        chk("to_rdata", rdata_o, 0);
        req_i = 2'b00;
        tick();

        // Reset in the second busy cycle: strobes drop at once, no done
        req_i = 2'b11;
        tick();
        chk("ra_gnt_dbg", gnt_o, 2'b10);
        tick();
        chk("ra_busy2", mem_rd_o, 1);
        rst_n = 1'b0;
        #1;
        chk("ra_strobes", {mem_rd_o, mem_wr_o}, 2'b00);
        chk("ra_done_now", done_o, 2'b00);
        tick();
        chk("ra_done_held", done_o, 2'b00);
        rst_n = 1'b1;
        tick();
        chk("ra_gnt_core", gnt_o, 2'b01);
        req_i = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
